reg_casillas: RTL and testbench
===============================

Name: reg_casillas

Overview:
- Occupancy register for a ROWS x COLS game board ("casillas" = cells).
- Each enabled request names one cell by row (fila) and column (columna).
- The block reports, one cycle later, whether the claim was accepted: the cell was in range and previously free. Accepted cells are marked occupied.
- Sits between the player-input/move FSM and the board renderer/win checker, which consume the occupancy map.

Parameters:
- ROWS, 6, number of board rows.
- COLS, 7, number of board columns.
- IDX_W, 3, width of fila/columna; must satisfy 2**IDX_W >= max(ROWS, COLS).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears the board
- fila  input  IDX_W  row index of requested cell, 0..ROWS-1
- columna  input  IDX_W  column index of requested cell, 0..COLS-1
- enable  input  1  request strobe; sampled every rising edge
- valid  output  1  registered; 1 = request sampled on previous edge was accepted
- occ_map  output  ROWS*COLS  occupancy bitmap; bit index fila*COLS+columna; 1 = occupied
- board_full  output  1  registered; 1 = all ROWS*COLS cells occupied

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset (rising edge with reset=1):
  - occ_map=0, valid=0, board_full=0, internal occupied count=0.
  - Reset has priority over enable; a request in the same cycle is discarded.
- Request evaluation at each rising edge with reset=0 and enable=1:
  - in_range = (fila < ROWS) && (columna < COLS).
  - free = in_range && !occ_map[fila*COLS+columna].
  - If free: set that occ_map bit, increment the count, valid <= 1.
  - Otherwise: no state change, valid <= 0.
- enable=0 at an edge: valid <= 0; occ_map unchanged.
- Latency:
  - valid is asserted exactly one cycle after the sampling edge.
  - valid is high for one cycle per accepted request; it is never held.
- Request held across edges:
  - enable high with the same cell for N consecutive edges produces valid 1 then 0 for the remaining N-1 cycles.
  - Each edge is an independent request.
- Out-of-range index (e.g. fila=6 or columna=7 with defaults) is rejected: valid=0 and no bit is written.
- board_full is updated on the same edge as the write that fills the last cell, so it is visible with that cell's valid=1.
- Once full, every further request returns valid=0.
- The count saturates at ROWS*COLS and never wraps.
- No cell is ever cleared except by reset.
- occ_map is a direct register output; no combinational path from inputs to any output.

Decomposition:
- Shared package board_pkg:
  - ROWS, COLS, IDX_W, CELLS = ROWS*COLS, CNT_W = $clog2(CELLS+1).
  - Function cell_idx(fila, columna) returning fila*COLS+columna.
  - typedef board_map_t = logic [CELLS-1:0].
- Optional sub-module cell_decoder: maps (fila, columna) to a one-hot CELLS-bit write mask plus in_range. It is shared with the win checker.
- Everything else stays in reg_casillas.

Test Plan:
- Reset held 2 cycles, then released -> valid=0, board_full=0, occ_map=0.
- enable=1 with requests (2,3), (0,0), (4,2), (2,3), one per cycle -> valid=1,1,1,0 on the following cycles; occ_map bits 17, 0 and 30 set, and only those.
- enable held 3 cycles on (5,6) -> valid=1,0,0; bit 41 set; count increments once.
- Out-of-range requests (6,0) and (0,7) -> valid=0; occ_map unchanged.
- Claim all 42 cells in order -> valid=1 each time; board_full rises with the 42nd acceptance; a further request (0,0) -> valid=0.
- Reset asserted mid-sequence together with enable=1 on (1,1) -> next cycle valid=0, occ_map=0; subsequent (1,1) accepted with valid=1.

Source files
------------

// File: rtl/board_pkg.sv
// Shared board geometry and helpers for the occupancy register, the input FSM
// and the win checker.
package board_pkg;

  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int IDX_W = 3;
  localparam int CELLS = ROWS * COLS;
  localparam int CNT_W = $clog2(CELLS + 1);

  typedef logic [CELLS-1:0] board_map_t;

  function automatic int cell_idx(input logic [IDX_W-1:0] fila,
                                  input logic [IDX_W-1:0] columna);
    return int'(fila) * COLS + int'(columna);
  endfunction

endpackage

// File: rtl/cell_decoder.sv
// Maps a (fila, columna) pair to a one-hot write mask over the board plus a
// range flag; an out-of-range pair yields an all-zero mask.
module cell_decoder
  import board_pkg::*;
#(
  parameter int ROWS_P  = ROWS,
  parameter int COLS_P  = COLS,
  parameter int IDX_W_P = IDX_W
) (
  input  logic [IDX_W_P-1:0]       fila,
  input  logic [IDX_W_P-1:0]       columna,
  output logic [ROWS_P*COLS_P-1:0] mask,
  output logic                     in_range
);

  // One extra bit so a dimension equal to 2**IDX_W still compares correctly.
  assign in_range = ({1'b0, fila}    < (IDX_W_P+1)'(ROWS_P)) &&
                    ({1'b0, columna} < (IDX_W_P+1)'(COLS_P));

  generate
    for (genvar gi = 0; gi < ROWS_P*COLS_P; gi++) begin : g_cell
      localparam logic [IDX_W_P-1:0] ROW_I = IDX_W_P'(gi / COLS_P);
      localparam logic [IDX_W_P-1:0] COL_I = IDX_W_P'(gi % COLS_P);
      assign mask[gi] = (fila == ROW_I) && (columna == COL_I);
    end
  endgenerate

endmodule

// File: rtl/reg_casillas.sv
// Board occupancy register: accepts a claim on a free, in-range cell, marks it
// occupied and reports acceptance one cycle later; flags when the board fills.
module reg_casillas
  import board_pkg::*;
#(
  parameter int ROWS_P  = ROWS,
  parameter int COLS_P  = COLS,
  parameter int IDX_W_P = IDX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IDX_W_P-1:0]       fila,
  input  logic [IDX_W_P-1:0]       columna,
  input  logic                     enable,
  output logic                     valid,
  output logic [ROWS_P*COLS_P-1:0] occ_map,
  output logic                     board_full
);

  localparam int N_CELLS = ROWS_P * COLS_P;
  localparam int N_CNT_W = $clog2(N_CELLS + 1);

  logic [N_CELLS-1:0] occ_reg;
  logic [N_CELLS-1:0] wr_mask;
  logic [N_CNT_W-1:0] count_reg;
  logic               valid_reg;
  logic               full_reg;
  logic               in_range;
  logic               accept;

  cell_decoder #(
    .ROWS_P  (ROWS_P),
    .COLS_P  (COLS_P),
    .IDX_W_P (IDX_W_P)
  ) u_decoder (
    .fila     (fila),
    .columna  (columna),
    .mask     (wr_mask),
    .in_range (in_range)
  );

  // A claim succeeds only if the addressed cell is currently free.
  assign accept = enable && in_range && (|(wr_mask & ~occ_reg));

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_reg   <= '0;
      count_reg <= '0;
      valid_reg <= 1'b0;
      full_reg  <= 1'b0;
    end else begin
      valid_reg <= accept;
      if (accept) begin
        occ_reg <= occ_reg | wr_mask;
        if (count_reg != N_CNT_W'(N_CELLS))
          count_reg <= count_reg + N_CNT_W'(1);
        full_reg <= (count_reg == N_CNT_W'(N_CELLS - 1));
      end
    end
  end

  assign valid      = valid_reg;
  assign occ_map    = occ_reg;
  assign board_full = full_reg;

endmodule

// File: tb/tb_reg_casillas.sv
// Directed self-checking bench for reg_casillas on the default 6x7 board.
module tb_reg_casillas;
  import board_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [IDX_W-1:0] fila;
  logic [IDX_W-1:0] columna;
  logic             enable;
  logic             valid;
  board_map_t       occ_map;
  logic             board_full;

  int checks = 0;
  int errors = 0;

  board_map_t exp_map;

  reg_casillas dut (
    .clk        (clk),
    .reset      (reset),
    .fila       (fila),
    .columna    (columna),
    .enable     (enable),
    .valid      (valid),
    .occ_map    (occ_map),
    .board_full (board_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample outputs 1ns after the edge.
  task automatic step(input logic rst, input logic en, input int f, input int c);
    reset   = rst;
    enable  = en;
    fila    = IDX_W'(f);
    columna = IDX_W'(c);
    @(posedge clk);
    #1;
    $display("txn rst=%0d en=%0d fila=%0d col=%0d -> valid=%0d full=%0d occ=%h",
             rst, en, f, c, valid, board_full, occ_map);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; fila = '0; columna = '0;
    #2;

    // Reset held two cycles, then released idle.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_full",  64'(board_full), 64'd0);
    check("rst_occ",   64'(occ_map), 64'd0);
    step(0, 0, 0, 0);
    check("idle_valid", 64'(valid), 64'd0);
    check("idle_occ",   64'(occ_map), 64'd0);

    // Basic claims, including a repeat of an occupied cell.
    step(0, 1, 2, 3); check("claim_2_3",  64'(valid), 64'd1);
    step(0, 1, 0, 0); check("claim_0_0",  64'(valid), 64'd1);
    step(0, 1, 4, 2); check("claim_4_2",  64'(valid), 64'd1);
    step(0, 1, 2, 3); check("repeat_2_3", 64'(valid), 64'd0);
    exp_map = '0;
    exp_map[17] = 1'b1; exp_map[0] = 1'b1; exp_map[30] = 1'b1;
    check("map_after_claims", 64'(occ_map), 64'(exp_map));

    // Request held for three edges on the last cell.
    step(0, 1, 5, 6); check("hold_1", 64'(valid), 64'd1);
    step(0, 1, 5, 6); check("hold_2", 64'(valid), 64'd0);
    step(0, 1, 5, 6); check("hold_3", 64'(valid), 64'd0);
    exp_map[41] = 1'b1;
    check("map_after_hold", 64'(occ_map), 64'(exp_map));
    step(0, 0, 1, 1); check("en_low_valid", 64'(valid), 64'd0);

    // Out-of-range indices are rejected without writing.
    step(0, 1, 6, 0); check("oor_row",  64'(valid), 64'd0);
    step(0, 1, 0, 7); check("oor_col",  64'(valid), 64'd0);
    step(0, 1, 7, 7); check("oor_both", 64'(valid), 64'd0);
    check("map_after_oor", 64'(occ_map), 64'(exp_map));
    check("not_full_yet", 64'(board_full), 64'd0);

    // Fresh board: claim every cell in order.
    step(1, 0, 0, 0);
    check("rst2_occ", 64'(occ_map), 64'd0);
    exp_map = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        step(0, 1, r, c);
        exp_map[r*COLS + c] = 1'b1;
        check($sformatf("fill_valid_%0d_%0d", r, c), 64'(valid), 64'd1);
        check($sformatf("fill_full_%0d_%0d", r, c), 64'(board_full),
              64'((r == ROWS-1) && (c == COLS-1)));
      end
    end
    check("fill_map", 64'(occ_map), 64'h3FF_FFFF_FFFF);
    step(0, 1, 0, 0); check("after_full_valid", 64'(valid), 64'd0);
    check("after_full_flag", 64'(board_full), 64'd1);
    step(0, 1, 3, 3); check("after_full_valid2", 64'(valid), 64'd0);

    // Reset wins over a simultaneous request.
    step(0, 1, 1, 1);
    step(1, 1, 1, 1);
    check("rst_mid_valid", 64'(valid), 64'd0);
    check("rst_mid_occ",   64'(occ_map), 64'd0);
    check("rst_mid_full",  64'(board_full), 64'd0);
    step(0, 1, 1, 1); check("post_rst_claim", 64'(valid), 64'd1);
    check("post_rst_map", 64'(occ_map), 64'h100);
    step(0, 0, 0, 0); check("post_rst_idle", 64'(valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
